regfile_sb: RTL

Parametrised successor to the 32x32 MIPS register file: WIDTH-bit by DEPTH-entry storage with two asynchronous read ports, one synchronous write port, optional hard-wired zero register, and optional write-to-read bypass. Adds a per-register pending-write scoreboard with a running count of outstanding producers. The pipeline decode stage uses it for load-use and multi-cycle interlock. Also adds a synchronous clear of all state.

---
 rtl/regfile_sb_pkg.sv | 21 ++
 rtl/regfile_scoreboard.sv | 66 ++++++
 rtl/regfile_sb.sv | 81 ++++++++
 3 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 32;

  // Per-cycle movement of the outstanding-producer count.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_step_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits with an incrementally maintained count.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  bit          ZERO_REG = 1'b1,
  localparam int unsigned AW       = clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          res_i,
  input  logic [AW-1:0] res_addr_i,
  input  logic [AW-1:0] rd_addr1_i,
  input  logic [AW-1:0] rd_addr2_i,
  output logic          busy1_o,
  output logic          busy2_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] ONE = (AW + 1)'(1);

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok, res_ok, inc, dec;
  cnt_step_e        step;

  always_comb begin
    wr_ok  = we_i && !(ZERO_REG && waddr_i == '0);
    res_ok = res_i && !(ZERO_REG && res_addr_i == '0);

    // Reserve is applied after the write clear so a same-register collision stays pending.
    pend_d = pend_q;
    if (wr_ok)  pend_d[waddr_i]    = 1'b0;
    if (res_ok) pend_d[res_addr_i] = 1'b1;

    inc = res_ok && !pend_q[res_addr_i];
    dec = wr_ok && pend_q[waddr_i] && !(res_ok && res_addr_i == waddr_i);

    step = CNT_HOLD;
    if (inc && !dec)      step = CNT_INC;
    else if (dec && !inc) step = CNT_DEC;

    case (step)
      CNT_INC: count_d = count_q + ONE;
      CNT_DEC: count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  assign busy1_o = pend_q[rd_addr1_i];
  assign busy2_o = pend_q[rd_addr2_i];
  assign count_o = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with optional zero register, write bypass
// and a pending-write scoreboard for decode-stage interlocks.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEF_WIDTH,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  bit          ZERO_REG = 1'b1,
  parameter  bit          BYPASS   = 1'b1,
  localparam int unsigned AW       = clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [AW-1:0]    ReadRegister1,
  input  logic [AW-1:0]    ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic             ReadBusy1,
  output logic             ReadBusy2,
  input  logic [AW-1:0]    WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             RegWrite,
  input  logic [AW-1:0]    ReserveRegister,
  input  logic             Reserve,
  output logic [AW:0]      PendingCount
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             wr_ok, byp1, byp2, zero1, zero2;
  logic             sb_busy1, sb_busy2;

  always_comb begin
    wr_ok = RegWrite && !(ZERO_REG && WriteRegister == '0);
    byp1  = BYPASS && wr_ok && (WriteRegister == ReadRegister1);
    byp2  = BYPASS && wr_ok && (WriteRegister == ReadRegister2);
    zero1 = ZERO_REG && (ReadRegister1 == '0);
    zero2 = ZERO_REG && (ReadRegister2 == '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[WriteRegister] <= WriteData;
    end
  end

  always_comb begin
    ReadData1 = zero1 ? '0 : regs_q[ReadRegister1];
    ReadData2 = zero2 ? '0 : regs_q[ReadRegister2];
    ReadBusy1 = sb_busy1;
    ReadBusy2 = sb_busy2;
    // A forwarded write is the value the consumer waits for, so it also lifts busy.
    if (byp1) begin
      ReadData1 = WriteData;
      ReadBusy1 = 1'b0;
    end
    if (byp2) begin
      ReadData2 = WriteData;
      ReadBusy2 = 1'b0;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .we_i       (RegWrite),
    .waddr_i    (WriteRegister),
    .res_i      (Reserve),
    .res_addr_i (ReserveRegister),
    .rd_addr1_i (ReadRegister1),
    .rd_addr2_i (ReadRegister2),
    .busy1_o    (sb_busy1),
    .busy2_o    (sb_busy2),
    .count_o    (PendingCount)
  );

endmodule
